// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Captures one ALU unit result (arith > logic > cmp > shift) and sends it as a
// valid/ready byte stream: a header byte, then the result bytes LSB-first.
// Only one frame is buffered. Any result that cannot be taken is dropped and
// recorded on the sticky OVERFLOW flag.
module alu_result_serializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2*DATA_WIDTH-1:0] ARITH_OUT,
    input  logic                    CARRY_OUT,
    input  logic                    ARITH_FLAG,
    input  logic [DATA_WIDTH-1:0]   LOGIC_OUT,
    input  logic                    LOGIC_FLAG,
    input  logic [DATA_WIDTH-1:0]   CMP_OUT,
    input  logic                    CMP_FLAG,
    input  logic [DATA_WIDTH-1:0]   SHIFT_OUT,
    input  logic                    SHIFT_FLAG,
    output logic [7:0]              TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    BUSY,
    output logic                    OVERFLOW,
    input  logic                    CLR_OVF
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned CW = $clog2(PW / 8 + 1);

    localparam logic [CW-1:0] ARITH_BYTES = CW'(PW / 8);
    localparam logic [CW-1:0] UNIT_BYTES  = CW'(DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t         state, state_next;
    logic [PW-1:0]  payload, payload_next;
    logic [CW-1:0]  nbytes, nbytes_next;
    logic [CW-1:0]  idx, idx_next;
    logic [7:0]     tx_data_q, tx_data_next;
    logic           tx_valid_q, tx_valid_next;
    logic           ovf_q, ovf_next;
    logic           any_flag;
    logic           drop;

    assign any_flag = ARITH_FLAG | LOGIC_FLAG | CMP_FLAG | SHIFT_FLAG;

    // Next-state, capture, byte selection and drop detection.
    // The payload shifts right on every data transfer, so the next byte to
    // send is always sitting in payload[15:8] when the current one goes out.
    always_comb begin
        state_next   = state;
        payload_next = payload;
        nbytes_next  = nbytes;
        idx_next     = idx;
        tx_data_next = tx_data_q;
        drop         = 1'b0;

        unique case (state)
            IDLE: begin
                idx_next     = '0;
                tx_data_next = '0;
                if (ARITH_FLAG) begin
                    payload_next = ARITH_OUT;
                    nbytes_next  = ARITH_BYTES;
                    tx_data_next = {4'h1, 3'b000, CARRY_OUT};
                    state_next   = HDR;
                    drop         = LOGIC_FLAG | CMP_FLAG | SHIFT_FLAG;
                end else if (LOGIC_FLAG) begin
                    payload_next                 = '0;
                    payload_next[DATA_WIDTH-1:0] = LOGIC_OUT;
                    nbytes_next                  = UNIT_BYTES;
                    tx_data_next                 = 8'h20;
                    state_next                   = HDR;
                    drop                         = CMP_FLAG | SHIFT_FLAG;
                end else if (CMP_FLAG) begin
                    payload_next                 = '0;
                    payload_next[DATA_WIDTH-1:0] = CMP_OUT;
                    nbytes_next                  = UNIT_BYTES;
                    tx_data_next                 = 8'h30;
                    state_next                   = HDR;
                    drop                         = SHIFT_FLAG;
                end else if (SHIFT_FLAG) begin
                    payload_next                 = '0;
                    payload_next[DATA_WIDTH-1:0] = SHIFT_OUT;
                    nbytes_next                  = UNIT_BYTES;
                    tx_data_next                 = 8'h40;
                    state_next                   = HDR;
                end
            end
            HDR: begin
                drop = any_flag;
                if (TX_READY) begin
                    state_next   = DATA;
                    idx_next     = '0;
                    tx_data_next = payload[7:0];
                end
            end
            DATA: begin
                drop = any_flag;
                if (TX_READY) begin
                    if (idx == nbytes - CW'(1)) begin
                        state_next   = IDLE;
                        idx_next     = '0;
                        tx_data_next = '0;
                    end else begin
                        idx_next     = idx + CW'(1);
                        payload_next = payload >> 8;
                        tx_data_next = payload[15:8];
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_valid_next = (state_next != IDLE);

        if (drop) begin
            ovf_next = 1'b1;
        end else if (CLR_OVF) begin
            ovf_next = 1'b0;
        end else begin
            ovf_next = ovf_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            payload    <= '0;
            nbytes     <= '0;
            idx        <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state      <= state_next;
            payload    <= payload_next;
            nbytes     <= nbytes_next;
            idx        <= idx_next;
            tx_data_q  <= tx_data_next;
            tx_valid_q <= tx_valid_next;
            ovf_q      <= ovf_next;
        end
    end

    assign TX_DATA  = tx_data_q;
    assign TX_VALID = tx_valid_q;
    assign BUSY     = (state != IDLE);
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_alu_result_serializer;

    localparam int unsigned DW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [2*DW-1:0] ARITH_OUT;
    logic          CARRY_OUT;
    logic          ARITH_FLAG;
    logic [DW-1:0] LOGIC_OUT;
    logic          LOGIC_FLAG;
    logic [DW-1:0] CMP_OUT;
    logic          CMP_FLAG;
    logic [DW-1:0] SHIFT_OUT;
    logic          SHIFT_FLAG;
    logic [7:0]    TX_DATA;
    logic          TX_VALID;
    logic          TX_READY;
    logic          BUSY;
    logic          OVERFLOW;
    logic          CLR_OVF;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_result_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ARITH_OUT (ARITH_OUT),
        .CARRY_OUT (CARRY_OUT),
        .ARITH_FLAG(ARITH_FLAG),
        .LOGIC_OUT (LOGIC_OUT),
        .LOGIC_FLAG(LOGIC_FLAG),
        .CMP_OUT   (CMP_OUT),
        .CMP_FLAG  (CMP_FLAG),
        .SHIFT_OUT (SHIFT_OUT),
        .SHIFT_FLAG(SHIFT_FLAG),
        .TX_DATA   (TX_DATA),
        .TX_VALID  (TX_VALID),
        .TX_READY  (TX_READY),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(TX_VALID), 32'd1);
        chk({tag, "_busy"},  32'(BUSY),     32'd1);
        chk({tag, "_data"},  32'(TX_DATA),  32'(exp));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(TX_VALID), 32'd0);
        chk({tag, "_busy"},  32'(BUSY),     32'd0);
    endtask

    initial begin
        RST = 1'b0; TX_READY = 1'b0; CLR_OVF = 1'b0;
        ARITH_OUT = '0; CARRY_OUT = 1'b0; ARITH_FLAG = 1'b0;
        LOGIC_OUT = '0; LOGIC_FLAG = 1'b0;
        CMP_OUT = '0; CMP_FLAG = 1'b0;
        SHIFT_OUT = '0; SHIFT_FLAG = 1'b0;

        // Reset held for 3 cycles with flags toggling
        for (int i = 0; i < 3; i++) begin
            ARITH_FLAG = (i != 1); LOGIC_FLAG = (i == 1);
            CMP_FLAG   = (i != 1); SHIFT_FLAG = 1'b1;
            tick();
            chk_idle("rst");
            chk("rst_data", 32'(TX_DATA),  32'h0);
            chk("rst_ovf",  32'(OVERFLOW), 32'd0);
        end
        ARITH_FLAG = 1'b0; LOGIC_FLAG = 1'b0; CMP_FLAG = 1'b0; SHIFT_FLAG = 1'b0;
        RST = 1'b1;
        tick();
        chk_idle("rel");

        // Stray TX_READY while idle
        TX_READY = 1'b1;
        tick();
        chk_idle("stray_rdy");
        chk("stray_data", 32'(TX_DATA), 32'h0);

        // Arith frame, ready high
        ARITH_OUT = 32'hA1B2C3D4; CARRY_OUT = 1'b1; ARITH_FLAG = 1'b1;
        tick();
        ARITH_FLAG = 1'b0; CARRY_OUT = 1'b0;
        chk_byte("ar_hdr", 8'h11);
        tick(); chk_byte("ar_b0", 8'hD4);
        tick(); chk_byte("ar_b1", 8'hC3);
        tick(); chk_byte("ar_b2", 8'hB2);
        tick(); chk_byte("ar_b3", 8'hA1);
        tick(); chk_idle("ar_end");
        chk("ar_ovf", 32'(OVERFLOW), 32'd0);

        // Logic frame with backpressure
        TX_READY = 1'b0; LOGIC_OUT = 16'h00FF; LOGIC_FLAG = 1'b1;
        tick();
        LOGIC_FLAG = 1'b0;
        chk_byte("lg_hdr", 8'h20);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_byte("lg_hold", 8'h20);
        end
        TX_READY = 1'b1;
        tick(); chk_byte("lg_b0", 8'hFF);
        tick(); chk_byte("lg_b1", 8'h00);
        tick(); chk_idle("lg_end");

        // Simultaneous CMP and SHIFT flags
        CMP_OUT = 16'h0003; SHIFT_OUT = 16'h1234; CMP_FLAG = 1'b1; SHIFT_FLAG = 1'b1;
        tick();
        CMP_FLAG = 1'b0; SHIFT_FLAG = 1'b0;
        chk_byte("sim_hdr", 8'h30);
        chk("sim_ovf", 32'(OVERFLOW), 32'd1);
        tick(); chk_byte("sim_b0", 8'h03);
        tick(); chk_byte("sim_b1", 8'h00);
        tick(); chk_idle("sim_end");
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("sim_clr", 32'(OVERFLOW), 32'd0);

        // Shift flag dropped during an arith frame
        ARITH_OUT = 32'h12345678; CARRY_OUT = 1'b0; ARITH_FLAG = 1'b1;
        tick();
        ARITH_FLAG = 1'b0;
        chk_byte("db_hdr", 8'h10);
        SHIFT_OUT = 16'hBEEF; SHIFT_FLAG = 1'b1;
        tick();
        SHIFT_FLAG = 1'b0;
        chk_byte("db_b0", 8'h78);
        chk("db_ovf", 32'(OVERFLOW), 32'd1);
        tick(); chk_byte("db_b1", 8'h56);
        tick(); chk_byte("db_b2", 8'h34);
        tick(); chk_byte("db_b3", 8'h12);
        tick(); chk_idle("db_end");
        tick(); chk_idle("db_noshift");
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        chk("db_clr", 32'(OVERFLOW), 32'd0);

        // Clear and drop in the same cycle; then a drop on the final transfer
        LOGIC_OUT = 16'h5AA5; LOGIC_FLAG = 1'b1;
        tick();
        LOGIC_FLAG = 1'b0;
        chk_byte("cd_hdr", 8'h20);
        CLR_OVF = 1'b1; SHIFT_FLAG = 1'b1;
        tick();
        SHIFT_FLAG = 1'b0;
        chk_byte("cd_b0", 8'hA5);
        chk("cd_set_wins", 32'(OVERFLOW), 32'd1);
        tick();
        CLR_OVF = 1'b0;
        chk_byte("cd_b1", 8'h5A);
        chk("cd_clr", 32'(OVERFLOW), 32'd0);
        CMP_OUT = 16'h7777; CMP_FLAG = 1'b1;
        tick();
        CMP_FLAG = 1'b0;
        chk_idle("last_drop_end");
        chk("last_drop_ovf", 32'(OVERFLOW), 32'd1);
        tick(); chk_idle("last_drop_nocap");

        // Reset mid-frame
        ARITH_OUT = 32'hA1B2C3D4; ARITH_FLAG = 1'b1;
        tick();
        ARITH_FLAG = 1'b0;
        chk_byte("mr_hdr", 8'h10);
        tick(); chk_byte("mr_b0", 8'hD4);
        tick(); chk_byte("mr_b1", 8'hC3);
        RST = 1'b0;
        tick();
        chk_idle("mr_rst");
        chk("mr_data", 32'(TX_DATA),  32'h0);
        chk("mr_ovf",  32'(OVERFLOW), 32'd0);
        RST = 1'b1;
        tick(); chk_idle("mr_rel");
        CMP_OUT = 16'hBEEF; CMP_FLAG = 1'b1;
        tick();
        CMP_FLAG = 1'b0;
        chk_byte("mr_hdr2", 8'h30);
        tick(); chk_byte("mr_c0", 8'hEF);
        tick(); chk_byte("mr_c1", 8'hBE);
        tick(); chk_idle("mr_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
